// File: rtl/apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arb
// Brief    : Two-requester round-robin APB master with wait-state and
//            pready-timeout handling; one response pulse per transfer.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam int              CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   c_TIMEOUT = CW'(TIMEOUT);
    localparam logic [1:0]      c_IDLE    = 2'd0;
    localparam logic [1:0]      c_SETUP   = 2'd1;
    localparam logic [1:0]      c_ACCESS  = 2'd2;

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic [CW-1:0] r_cnt;
    logic          w_grant;
    logic          w_hs;
    logic          w_cnt_hit;

    // Under contention the requester that was not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid)
            w_grant = ~r_last_grant;
        else if (req1_valid)
            w_grant = 1'b1;
    end

    assign req0_ready = (r_state == c_IDLE) && !w_grant && req0_valid;
    assign req1_ready = (r_state == c_IDLE) &&  w_grant && req1_valid;
    assign w_hs       = req0_ready || req1_ready;
    assign w_cnt_hit  = (r_cnt + CW'(1)) == c_TIMEOUT;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            psel         <= 1'b0;
            penable      <= 1'b0;
            pwrite       <= 1'b0;
            paddr        <= '0;
            pwdata       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_hs) begin
                        r_state      <= c_SETUP;
                        psel         <= 1'b1;
                        r_last_grant <= w_grant;
                        pwrite       <= w_grant ? req1_write : req0_write;
                        paddr        <= w_grant ? req1_addr  : req0_addr;
                        pwdata       <= w_grant ? req1_wdata : req0_wdata;
                    end
                end
                c_SETUP: begin
                    r_state <= c_ACCESS;
                    penable <= 1'b1;
                    r_cnt   <= '0;
                end
                c_ACCESS: begin
                    // pready takes priority over a timeout in the same cycle.
                    if (pready) begin
                        r_state   <= c_IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_last_grant;
                        rsp_err   <= pslverr;
                        rsp_rdata <= (!pwrite && !pslverr) ? prdata : 32'h0;
                    end else if (w_cnt_hit) begin
                        r_state   <= c_IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        r_cnt     <= r_cnt + CW'(1);
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_last_grant;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_arb
// Brief    : Directed scoreboard bench for apb_master_arb.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb_master_arb;

    localparam int TIMEOUT = 16;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        req0_valid, req0_ready, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    apb_master_arb #(.TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          plen;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int          slv_wait  = 0;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_err   = 1'b0;
    logic        slv_hang  = 1'b0;
    logic        slv_noise = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outcome of a transfer given the slave behaviour at handshake time.
    function automatic exp_t mk(input logic id, input logic w, input logic [31:0] a,
                                input logic [31:0] d);
        exp_t e;
        e.id = id; e.addr = a; e.write = w; e.wdata = d;
        if (slv_hang) begin
            e.err = 1'b1; e.rdata = 32'h0; e.cyc = cyc + 2 + TIMEOUT; e.plen = 1 + TIMEOUT;
        end else begin
            e.err   = slv_err;
            e.rdata = (w || slv_err) ? 32'h0 : slv_rdata;
            e.cyc   = cyc + 3 + slv_wait;
            e.plen  = 2 + slv_wait;
        end
        return e;
    endfunction

    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    // Slave model: pready after slv_wait low ACCESS cycles, never if hung.
    initial begin
        int wc;
        wc = 0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        forever begin
            @(negedge pclk);
            if (psel && penable) begin
                if (!slv_hang && wc >= slv_wait) begin
                    pready = 1'b1; pslverr = slv_err; prdata = slv_rdata;
                end else begin
                    pready = 1'b0; pslverr = slv_noise; prdata = 32'hBAD0BAD0;
                end
                wc++;
            end else begin
                pready = 1'b0; pslverr = 1'b0; wc = 0;
            end
        end
    end

    // Monitor: push on handshake, track bus phase, pop and compare on response.
    initial begin
        int          plen_cur, pen_cur, plen_last, pen_last;
        logic        unstable;
        logic [31:0] cap_addr, cap_wdata;
        logic        cap_write;
        exp_t        e;
        plen_cur = 0; pen_cur = 0; plen_last = 0; pen_last = 0; unstable = 1'b0;
        cap_addr = 32'h0; cap_wdata = 32'h0; cap_write = 1'b0;
        forever begin
            @(negedge pclk);
            if (preset_n && (req0_ready || req1_ready)) begin
                check("one_ready", 32'(req0_ready && req1_ready), 32'h0);
                if (req0_ready) begin
                    sb.push_back(mk(1'b0, req0_write, req0_addr, req0_wdata));
                    gq.push_back(0);
                end
                if (req1_ready) begin
                    sb.push_back(mk(1'b1, req1_write, req1_addr, req1_wdata));
                    gq.push_back(1);
                end
            end
            if (psel) begin
                if (plen_cur == 0) begin
                    cap_addr = paddr; cap_wdata = pwdata; cap_write = pwrite; unstable = 1'b0;
                end else if (paddr !== cap_addr || pwdata !== cap_wdata || pwrite !== cap_write) begin
                    unstable = 1'b1;
                end
                plen_cur++;
                if (penable) pen_cur++;
            end else if (plen_cur != 0) begin
                plen_last = plen_cur; pen_last = pen_cur; plen_cur = 0; pen_cur = 0;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("stray_rsp", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_cycle", cyc, e.cyc);
                    check("psel_len", plen_last, e.plen);
                    check("penable_len", pen_last, e.plen - 1);
                    check("paddr", cap_addr, e.addr);
                    check("pwrite", 32'(cap_write), 32'(e.write));
                    if (e.write) check("pwdata", cap_wdata, e.wdata);
                    check("bus_stable", 32'(unstable), 32'h0);
                end
            end
        end
    end

    task automatic xfer(input logic id, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        logic hs;
        n = 0; hs = 1'b0;
        @(posedge pclk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
        end
        while (!hs && n < 100) begin
            @(negedge pclk);
            hs = id ? req1_ready : req0_ready;
            n++;
        end
        check("handshake", 32'(hs), 32'h1);
        @(posedge pclk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || psel) && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check("drain", sb.size(), 32'h0);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        preset_n = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
        repeat (3) @(negedge pclk);
        check("rst_psel", 32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_pwrite", 32'(pwrite), 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        preset_n = 1'b1;

        // Single zero-wait read on req0.
        slv_wait = 0; slv_rdata = 32'hDEADBEEF;
        xfer(1'b0, 1'b0, 32'h10, 32'h0);
        wait_idle();
        repeat (3) @(negedge pclk);
        check("hold_rdata", rsp_rdata, 32'hDEADBEEF);
        check("hold_id", 32'(rsp_id), 32'h0);
        check("idle_paddr", paddr, 32'h10);

        // Write on req1 with three wait states.
        slv_wait = 3; slv_rdata = 32'h11112222;
        xfer(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        wait_idle();

        // pslverr during waits ignored, then a real slave error.
        slv_wait = 2; slv_noise = 1'b1; slv_rdata = 32'h0BADF00D;
        xfer(1'b0, 1'b0, 32'h30, 32'h0);
        wait_idle();
        slv_wait = 0; slv_noise = 1'b0; slv_err = 1'b1;
        xfer(1'b1, 1'b0, 32'h34, 32'h0);
        wait_idle();
        slv_err = 1'b0;

        // pready on the last allowed ACCESS cycle completes normally.
        slv_wait = TIMEOUT - 1; slv_rdata = 32'hCAFE0001;
        xfer(1'b0, 1'b0, 32'h40, 32'h0);
        wait_idle();

        // Timeout, then a normal transfer.
        slv_hang = 1'b1;
        xfer(1'b1, 1'b0, 32'h50, 32'h0);
        wait_idle();
        slv_hang = 1'b0; slv_wait = 1; slv_rdata = 32'h600D600D;
        xfer(1'b1, 1'b0, 32'h54, 32'h0);
        wait_idle();

        // Reset during a wait state.
        slv_hang = 1'b1;
        xfer(1'b0, 1'b0, 32'h60, 32'h0);
        repeat (4) @(negedge pclk);
        check("pre_rst_penable", 32'(penable), 32'h1);
        #2 preset_n = 1'b0;
        #1;
        check("arst_psel", 32'(psel), 32'h0);
        check("arst_penable", 32'(penable), 32'h0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        sb.delete();
        slv_hang = 1'b0;
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        repeat (6) @(negedge pclk);

        // Contention after reset: strict alternation starting with req0.
        gq.delete();
        slv_wait = 0; slv_rdata = 32'h77778888;
        @(posedge pclk); #1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h100; req0_wdata = 32'h0;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h200; req1_wdata = 32'h55AA55AA;
        n = 0;
        while (gq.size() < 4 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        @(posedge pclk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        check("grant_count", gq.size(), 32'h4);
        if (gq.size() == 4) begin
            check("grant0", gq[0], 32'h0);
            check("grant1", gq[1], 32'h1);
            check("grant2", gq[2], 32'h0);
            check("grant3", gq[3], 32'h1);
        end

        repeat (3) @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_arb.md
# apb_master_arb

APB master controller that shares a single APB bus between two local requesters. It arbitrates requests round-robin and sequences the IDLE/SETUP/ACCESS protocol, including wait states and slave errors. It also terminates transfers whose slave never asserts pready. It drives the master side of the APB interface and returns one response per accepted request.

## Interface
- TIMEOUT, 16, maximum ACCESS cycles waited for pready before forced termination (≥2)
- pclk  in  1  bus clock; all logic is rising-edge
- preset_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  requester N (N=0,1) has a transfer pending
- reqN_ready  out  1  requester N's transfer is accepted this cycle
- reqN_write  in  1  1=write, 0=read
- reqN_addr  in  32  transfer address
- reqN_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  requester index the response belongs to
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  pslverr seen, or timeout
- psel, penable, pwrite  out  1  APB controls
- paddr, pwdata  out  32  APB address and write data
- prdata  in  32  APB read data
- pready, pslverr  in  1  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Arbiter picks the grant: if only one reqN_valid is high, grant it. If both are high, grant the requester other than last_grant.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. This output is combinational, and at most one ready is high.
  - On handshake: latch write/addr/wdata into paddr/pwrite/pwdata, set last_grant=N, go to SETUP.
- SETUP: psel=1, penable=0. Always lasts exactly one cycle, then go to ACCESS. Clear the timeout counter.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata stay stable from SETUP until the transfer ends.
  - pready=1: transfer ends. Capture pslverr into rsp_err. If read and no error, capture prdata into rsp_rdata; otherwise rsp_rdata=0. Go to IDLE.
  - pready=0: increment the timeout counter. When the counter reaches TIMEOUT, transfer ends with rsp_err=1 and rsp_rdata=0; go to IDLE.
  - pslverr is ignored whenever pready=0.
- Response: rsp_valid pulses exactly one cycle, the cycle after the transfer ends. rsp_id equals the granted index. rsp_id, rsp_rdata and rsp_err hold their values until the next response.
- There is no back-to-back SETUP. Every transfer passes through IDLE, so the next handshake can happen in the same cycle as rsp_valid.
- Requester obligation: reqN_* must be held stable while reqN_valid=1 and ready=0. Dropping valid before the handshake is permitted.
- Timeout counter width is $clog2(TIMEOUT+1). The counter never wraps.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - state=IDLE, last_grant=1 (so req0 wins the first contention)
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0
  - rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, counter=0
- Reset mid-transfer: psel/penable drop immediately. No response is generated for the aborted transfer.
- Latency with handshake at cycle T:
  - T+1: SETUP
  - T+2: first ACCESS cycle
  - Zero-wait slave (pready at T+2): rsp_valid at T+3
  - Each wait cycle adds 1 cycle
  - Timeout case: last ACCESS cycle is T+1+TIMEOUT, rsp_valid at T+2+TIMEOUT
- In IDLE: psel=0 and penable=0. paddr/pwdata/pwrite keep their last values.
- Outputs change only on the pclk rising edge, except reqN_ready.
- Simultaneous events:
  - A new request arriving during SETUP/ACCESS waits; ready stays 0.
  - If pready=1 in the same cycle the counter would reach TIMEOUT, pready wins: normal completion, with rsp_err=pslverr.

## Test plan
- Single read, zero wait: req0 read addr 0x10, slave returns prdata=0xDEADBEEF with pready at first ACCESS. Required: psel high for 2 cycles, penable high for 1 cycle, rsp_valid 3 cycles after handshake, rsp_id=0, rdata=0xDEADBEEF, err=0.
- Wait states plus write: req1 write addr 0x20, wdata 0xA5A5A5A5, pready after 3 low ACCESS cycles. Required: paddr/pwdata stable throughout, rsp at handshake+6, rsp_rdata=0, err=0.
- Contention: both valid continuously for 4 transfers from reset. Required: grant order 0,1,0,1, each rsp_id matching, no overlap of psel phases.
- Slave error: read with pready=1 and pslverr=1. Required: rsp_err=1, rsp_rdata=0. Also, pslverr=1 while pready=0 has no effect.
- Timeout: TIMEOUT=16, pready held 0. Required: ACCESS lasts exactly 16 cycles, psel/penable drop, rsp_err=1 at handshake+18. A following request then completes normally.
- Reset mid-ACCESS: assert preset_n=0 during a wait state. Required: psel/penable/rsp_valid go 0 asynchronously. After release, state is IDLE, there is no stray response, and req0 wins the first contention.
